// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_ram_pkg
// Shared types and constants for the SPI-to-RAM slave front end.
// Rev    : 1.0
// ============================================================================
package spi_ram_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int WORD_W        = ADDR_SIZE_DEF + 2;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    // Sub-phase of READ_DATA; TX_DONE parks the slave until ss_n rises.
    typedef enum logic [1:0] {
        PH_RX       = 2'd0,
        PH_TX_WAIT  = 2'd1,
        PH_TX_SHIFT = 2'd2,
        PH_TX_DONE  = 2'd3
    } rd_phase_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module : spi_slave_if
// SPI slave: deserialises command words from MOSI, serialises RAM bytes on MISO.
// Rev    : 1.0
// ============================================================================
module spi_slave_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int W     = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] RX_DONE = CNT_W'(W);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(ADDR_SIZE - 1);

    state_e                 state_q, state_d;
    rd_phase_e              phase_q, phase_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [W-2:0]           rx_shift_q, rx_shift_d;
    logic [W-1:0]           rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rd_addr_seen_q, rd_addr_seen_d;
    logic [ADDR_SIZE-1:0]   tx_shift_q, tx_shift_d;
    logic                   miso_q, miso_d;
    logic                   rx_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            phase_q        <= PH_RX;
            cnt_q          <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_shift_q     <= '0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_shift_q     <= tx_shift_d;
            miso_q         <= miso_d;
        end
    end

    // The command MSB arrives on the CHK_CMD edge and picks the response path.
    always_comb begin
        state_d = state_q;
        if (ss_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CHK_CMD;
                CHK_CMD: begin
                    if (!mosi)               state_d = WRITE;
                    else if (rd_addr_seen_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        phase_d        = phase_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_shift_d     = tx_shift_q;
        miso_d         = miso_q;
        rx_step        = 1'b0;

        if (ss_n) begin
            cnt_d   = '0;
            phase_d = PH_RX;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    phase_d = PH_RX;
                end
                CHK_CMD: begin
                    rx_shift_d = {rx_shift_q[W-3:0], mosi};
                    cnt_d      = CNT_W'(1);
                    phase_d    = PH_RX;
                end
                WRITE, READ_ADD: rx_step = 1'b1;
                READ_DATA: begin
                    case (phase_q)
                        PH_RX: rx_step = 1'b1;
                        PH_TX_WAIT: begin
                            if (tx_valid) begin
                                miso_d     = tx_data[ADDR_SIZE-1];
                                tx_shift_d = {tx_data[ADDR_SIZE-2:0], 1'b0};
                                cnt_d      = '0;
                                phase_d    = PH_TX_SHIFT;
                            end
                        end
                        PH_TX_SHIFT: begin
                            if (cnt_q == TX_LAST) begin
                                miso_d  = 1'b0;
                                phase_d = PH_TX_DONE;
                            end else begin
                                miso_d     = tx_shift_q[ADDR_SIZE-1];
                                tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                                cnt_d      = cnt_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase

            // cnt_q == RX_DONE means the word is complete; later MOSI bits are dropped.
            if (rx_step) begin
                if (cnt_q < RX_LAST) begin
                    rx_shift_d = {rx_shift_q[W-3:0], mosi};
                    cnt_d      = cnt_q + 1'b1;
                end else if (cnt_q == RX_LAST) begin
                    rx_data_d  = {rx_shift_q, mosi};
                    rx_valid_d = 1'b1;
                    cnt_d      = RX_DONE;
                    if (state_q == READ_ADD) begin
                        rd_addr_seen_d = 1'b1;
                    end
                    if (state_q == READ_DATA) begin
                        rd_addr_seen_d = 1'b0;
                        phase_d        = PH_TX_WAIT;
                    end
                end
            end
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_slave_if
// Self-checking bench for spi_slave_if with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_spi_slave_if;
    import spi_ram_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ss_n;
    logic          mosi;
    logic          miso;
    logic [AW+1:0] rx_data;
    logic          rx_valid;
    logic [AW-1:0] tx_data;
    logic          tx_valid;

    spi_slave_if #(.ADDR_SIZE(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       chk_en   = 1'b0;
    logic       exp_rv   = 1'b0;
    logic [9:0] exp_rd   = '0;
    logic       exp_miso = 1'b0;
    logic [9:0] m_rx_data = '0;
    bit         m_rd_seen = 1'b0;
    int         cur_e = -1;
    logic       cap_miso [0:63];
    logic       cap_rv   [0:63];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("rx_valid", {9'b0, rx_valid}, {9'b0, exp_rv});
            check("rx_data", rx_data, exp_rd);
            check("miso", {9'b0, miso}, {9'b0, exp_miso});
            if (cur_e >= 0 && cur_e < 64) begin
                cap_miso[cur_e] = miso;
                cap_rv[cur_e]   = rx_valid;
            end
        end
    end

    function automatic logic [7:0] cap_byte(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = cap_miso[s+i];
        return b;
    endfunction

    // Drive one edge's inputs at the falling edge, along with what must be seen after the next rising edge.
    task automatic tick(input logic ss, input logic m, input logic tv, input logic [7:0] td,
                        input logic erv, input logic em, input int e);
        @(negedge clk);
        ss_n     = ss;
        mosi     = m;
        tx_valid = tv;
        tx_data  = td;
        exp_rv   = erv;
        exp_rd   = m_rx_data;
        exp_miso = em;
        cur_e    = e;
    endtask

    // Frame edge E0 is the IDLE edge, E1..E10 carry word bits 9..0 MSB first.
    task automatic do_frame(input logic [9:0] word, input int nbits, input int delay,
                            input logic [7:0] rbyte, input int extra, input int gap);
        bit         rd_data;
        bit         done;
        int         last;
        int         ld;
        logic       m;
        logic       tv;
        logic [7:0] td;
        logic       erv;
        logic       em;
        rd_data = word[9] && m_rd_seen;
        done    = (nbits == 10);
        last    = nbits + (done ? extra : 0);
        ld      = 10 + delay;
        for (int i = 0; i < 64; i++) begin
            cap_miso[i] = 1'b0;
            cap_rv[i]   = 1'b0;
        end
        tick(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0, 0);
        for (int e = 1; e <= last; e++) begin
            m   = (e <= nbits) ? word[10-e] : 1'($urandom);
            tv  = 1'($urandom);
            td  = 8'($urandom);
            erv = 1'b0;
            em  = 1'b0;
            if (done && e == 10) begin
                m_rx_data = word;
                erv       = 1'b1;
                if (word[9]) m_rd_seen = !m_rd_seen;
            end
            if (done && rd_data && e > 10) begin
                tv = (e >= ld);
                if (e == ld) td = rbyte;
                if (e >= ld && e <= ld + 7) em = rbyte[7-(e-ld)];
            end
            tick(1'b0, m, tv, td, erv, em, e);
        end
        for (int g = 0; g < gap; g++) begin
            tick(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0, -1);
        end
    endtask

    initial begin
        logic [9:0] w;
        int         nb;
        int         dl;
        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        #12;
        check("reset rx_data", rx_data, 10'h000);
        check("reset rx_valid", {9'b0, rx_valid}, 10'h000);
        check("reset miso", {9'b0, miso}, 10'h000);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1);

        do_frame({WR_ADDR, 8'h3A}, 10, 1, 8'h00, 3, 2);
        check("f1 rx_data", rx_data, 10'h03A);
        check("f1 rv E9", {9'b0, cap_rv[9]}, 10'h000);
        check("f1 rv E10", {9'b0, cap_rv[10]}, 10'h001);
        check("f1 rv E11", {9'b0, cap_rv[11]}, 10'h000);

        do_frame({WR_DATA, 8'hC5}, 10, 1, 8'h00, 4, 1);
        check("f2 rx_data", rx_data, 10'h1C5);
        check("f2 miso quiet", {2'b0, cap_byte(6)}, 10'h000);

        do_frame({RD_ADDR, 8'h3A}, 10, 1, 8'h00, 2, 1);
        check("f3 rx_data", rx_data, 10'h23A);

        do_frame({RD_DATA, 8'hA5}, 10, 2, 8'hC5, 10, 1);
        check("f4 rx_data", rx_data, 10'h3A5);
        check("f4 miso E11", {9'b0, cap_miso[11]}, 10'h000);
        check("f4 miso E12-19", {2'b0, cap_byte(12)}, 10'h0C5);
        check("f4 miso E20", {9'b0, cap_miso[20]}, 10'h000);

        do_frame({WR_ADDR, 8'hAB}, 6, 1, 8'h00, 0, 1);
        check("trunc rx_data held", rx_data, 10'h3A5);
        do_frame({WR_ADDR, 8'hF0}, 10, 1, 8'h00, 2, 1);
        check("f5 rx_data", rx_data, 10'h0F0);

        // Reset while the third read bit is on MISO.
        do_frame({RD_ADDR, 8'hFF}, 10, 1, 8'h00, 0, 1);
        do_frame({RD_DATA, 8'h11}, 10, 2, 8'hA7, 4, 0);
        @(posedge clk);
        #2;
        check("pre-reset miso bits", {7'b0, cap_miso[12], cap_miso[13], cap_miso[14]}, 10'h005);
        #1;
        rst_n     = 1'b0;
        cur_e     = -1;
        m_rx_data = '0;
        m_rd_seen = 1'b0;
        exp_rv    = 1'b0;
        exp_rd    = '0;
        exp_miso  = 1'b0;
        #1;
        check("async rst miso", {9'b0, miso}, 10'h000);
        check("async rst rx_valid", {9'b0, rx_valid}, 10'h000);
        check("async rst rx_data", rx_data, 10'h000);
        @(negedge clk);
        ss_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1);

        do_frame({RD_DATA, 8'hC3}, 10, 1, 8'h5A, 12, 1);
        check("post-rst cmd is addr", rx_data, 10'h3C3);
        check("post-rst no miso", {2'b0, cap_byte(11)}, 10'h000);
        do_frame({RD_DATA, 8'h00}, 10, 6, 8'h81, 16, 1);
        check("slow tx miso E15", {9'b0, cap_miso[15]}, 10'h000);
        check("slow tx miso E16-23", {2'b0, cap_byte(16)}, 10'h081);
        check("slow tx miso E24", {9'b0, cap_miso[24]}, 10'h000);

        for (int k = 0; k < 40; k++) begin
            w  = 10'($urandom);
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : 10;
            dl = $urandom_range(1, 6);
            do_frame(w, nb, dl, 8'($urandom), $urandom_range(0, dl + 12), $urandom_range(1, 3));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
